// File: rtl/exhaustive_test_sequencer_pkg.sv
// exhaustive_test_sequencer_pkg: shared state type and default sizing
package exhaustive_test_sequencer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SETTLE = 2;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
endpackage

// File: rtl/exhaustive_test_sequencer_golden_adder.sv
// golden_adder: reference a+b+cin at WIDTH+1 bits
module golden_adder
  import exhaustive_test_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   y
);
  assign y = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/exhaustive_test_sequencer.sv
// exhaustive_test_sequencer: walks every {cin,a,b} through an external adder and logs mismatches
module exhaustive_test_sequencer
  import exhaustive_test_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 cin,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_cin
);
  localparam int IW = 2*WIDTH+1;
  localparam int EW = 2*WIDTH+2;
  localparam int CW = $clog2(SETTLE+1);
  state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] expect_y;
  logic mism, last, settled;
  golden_adder #(.WIDTH(WIDTH)) u_golden (.a(a), .b(b), .cin(cin), .y(expect_y));
  // the driven operands are the vector index itself, so they are flop outputs
  assign {cin, a, b} = idx;
  assign mism = {cout, sum} != expect_y;
  assign last = &idx;
  assign settled = cnt == CW'(SETTLE-1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_count <= '0;
      {fail_cin, fail_a, fail_b} <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= DRIVE;
            idx <= '0;
            cnt <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            error <= 1'b0;
            err_count <= '0;
            {fail_cin, fail_a, fail_b} <= '0;
          end
        DRIVE: begin
          cnt <= settled ? '0 : cnt + CW'(1);
          state <= settled ? CHECK : DRIVE;
        end
        CHECK: begin
          if (mism) begin
            err_count <= err_count + EW'(1);
            error <= 1'b1;
            if (!error) {fail_cin, fail_a, fail_b} <= idx;
          end
          // the final vector stays on the bus through DONE
          idx <= last ? idx : idx + IW'(1);
          state <= last ? DONE : DRIVE;
          busy <= !last;
          done <= last;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_exhaustive_test_sequencer.sv
// tb_exhaustive_test_sequencer: scoreboarded runs against a ripple adder with selectable stuck-at faults
module tb_exhaustive_test_sequencer;
  localparam int W = 4;
  localparam int S = 2;
  localparam int RUN = (1 << (2*W+1)) * (S+1);
  typedef struct {longint ts; int err; int cnt; int fa; int fb; int fc;} exp_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [W-1:0] a, b, sum, fail_a, fail_b, rs;
  logic cin, cout, busy, done, error, fail_cin, rc;
  logic [2*W+1:0] err_count;
  int fault = 0;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  exhaustive_test_sequencer #(.WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .error(error),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin)
  );
  always #5 clk = ~clk;
  always_comb begin
    logic c;
    c = cin;
    rs = '0;
    for (int i = 0; i < W; i++) begin
      rs[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    rc = c;
  end
  assign sum = fault == 1 ? {rs[W-1:1], 1'b0} : rs;
  assign cout = fault == 2 ? 1'b0 : rc;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_operands"}, {cin, a, b}, 0);
    chk({tag, "_fail_vec"}, {fail_cin, fail_a, fail_b}, 0);
  endtask
  task automatic go(input int err, input int cnt, input int fa, input int fb, input int fc);
    exp_t e;
    @(negedge clk);
    start = 1;
    e.ts = $time + 5;
    e.err = err;
    e.cnt = cnt;
    e.fa = fa;
    e.fb = fb;
    e.fc = fc;
    sb.push_back(e);
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < RUN + 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask
  initial begin : monitor
    exp_t e;
    logic pd;
    pd = 0;
    forever begin
      @(negedge clk);
      if (done && !pd) begin
        if (sb.size() == 0) chk("unexpected_done", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("done_cycle", ($time - e.ts - 5) / 10, RUN);
          chk("error", error, e.err);
          chk("err_count", err_count, e.cnt);
          chk("fail_a", fail_a, e.fa);
          chk("fail_b", fail_b, e.fb);
          chk("fail_cin", fail_cin, e.fc);
          chk("busy_in_done", busy, 0);
        end
      end
      pd = done;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    go(0, 0, 0, 0, 0);
    wait_idle("clean");
    fault = 1;
    go(1, 256, 0, 1, 0);
    wait_idle("sum0_stuck");
    fault = 2;
    go(1, 256, 1, 15, 0);
    wait_idle("cout_stuck");
    fault = 0;
    go(0, 0, 0, 0, 0);
    chk("restart_error_cleared", error, 0);
    chk("restart_count_cleared", err_count, 0);
    chk("restart_fail_cleared", {fail_cin, fail_a, fail_b}, 0);
    wait_idle("restart_from_done");
    go(0, 0, 0, 0, 0);
    repeat (48) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_ignored_start", busy, 1);
    wait_idle("ignored_start");
    fault = 1;
    go(1, 256, 0, 1, 0);
    repeat (98) @(negedge clk);
    chk("pre_reset_error", error, 1);
    #2 rst_n = 0;
    #1 check_zero("midrun_reset");
    sb.delete();
    @(negedge clk);
    check_zero("held_reset");
    rst_n = 1;
    fault = 0;
    go(0, 0, 0, 0, 0);
    wait_idle("after_reset");
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exhaustive_test_sequencer.md
EXHAUSTIVE_TEST_SEQUENCER -- requirements
Module: exhaustive_test_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand width of the adder under test.
REQ-002 Parameter SETTLE, default 2, minimum 1, SHALL set the cycles each vector is held before checking.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  run request, sampled in IDLE or DONE only.
REQ-007 a  output  WIDTH  operand A to the adder under test, registered.
REQ-008 b  output  WIDTH  operand B to the adder under test, registered.
REQ-009 cin  output  1  carry-in to the adder under test, registered.
REQ-010 sum  input  WIDTH  sum returned by the adder under test.
REQ-011 cout  input  1  carry-out returned by the adder under test.
REQ-012 busy  output  1  high in DRIVE and CHECK.
REQ-013 done  output  1  level, high in DONE.
REQ-014 error  output  1  sticky, set on the first mismatch of a run.
REQ-015 err_count  output  2*WIDTH+2  number of mismatching vectors in the current run.
REQ-016 fail_a, fail_b, fail_cin  output  WIDTH, WIDTH, 1  first failing vector of the run.

Function
REQ-017 The FSM SHALL have four states: IDLE, DRIVE, CHECK, DONE.
REQ-018 In IDLE or DONE, start=1 at a rising edge SHALL clear a, b, cin, error, err_count and the fail_* outputs, and SHALL enter DRIVE.
REQ-019 The vector index SHALL be {cin,a,b}, 2*WIDTH+1 bits, starting at 0, with b varying fastest, then a, then cin.
REQ-020 DRIVE SHALL hold the vector for exactly SETTLE cycles, using a settle counter, and SHALL then enter CHECK.
REQ-021 CHECK SHALL last 1 cycle and SHALL compare {cout,sum} against a+b+cin, computed at WIDTH+1 bits.
REQ-022 On a mismatch, err_count SHALL increment and error SHALL set; fail_* SHALL capture {a,b,cin} only when error was 0 before that edge.
REQ-023 After CHECK, an index of all-ones SHALL go to DONE; any other index SHALL increment and return to DRIVE.
REQ-024 done SHALL rise exactly 2^(2*WIDTH+1)*(SETTLE+1) cycles after the edge that sampled start.
REQ-025 In DONE, a, b, cin, error, err_count and fail_* SHALL hold until the next start.
REQ-026 start while busy SHALL be ignored.
REQ-027 err_count SHALL NOT overflow, because its width covers all 2^(2*WIDTH+1) vectors.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and zero every output and internal counter, including mid-run.
REQ-029 After reset is released, the first start SHALL begin a complete run from index 0.

Structure
REQ-030 A shared package SHALL hold the state enum and the default WIDTH and SETTLE constants.
REQ-031 One sub-module, golden_adder, SHALL compute the WIDTH+1-bit expected value a+b+cin combinationally.
REQ-032 The sequencer SHALL contain no behavioural delays, and all outputs SHALL be registered.

Verification
REQ-033 Bench configuration: WIDTH=4, SETTLE=2, with a correct 4-bit ripple-carry adder attached.
- Correct DUT, start pulse -> done high after 1536 cycles; error=0; err_count=0.
- sum[0] stuck at 0 -> err_count=256; fail_a=0, fail_b=1, fail_cin=0.
- cout stuck at 0 -> err_count=256; fail_a=1, fail_b=15, fail_cin=0.
- start re-pulsed 50 cycles into a run -> ignored; done still at cycle 1536 of the original run.
- rst_n low at cycle 100 -> all outputs 0 and state IDLE within the same cycle; a new start completes a full 1536-cycle run.
- Start from DONE after a faulty run, with the fault removed -> error, err_count and fail_* cleared; clean run completes.
